dmem_responder: RTL

Memory-side responder for the pipelined core's MEM-stage load/store requests. Serves a small data RAM plus memory-mapped GPIO registers, with a configurable number of wait states.
Uses a valid/ready handshake. The core stalls its pipeline while req_valid is high and req_ready is low.
Sits between the core's MEM stage and on-board I/O, replacing the zero-latency data memory.

---
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data RAM + GPIO responder with wait states.
// Define DMEM_TIMER_EN to add a free-running cycle counter at 0xF2.
module dmem_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_DEPTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    input  logic [7:0]            gpio_in,
    output logic [7:0]            gpio_out
);

    localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] A_GOUT = ADDR_WIDTH'(8'hF0);
    localparam logic [ADDR_WIDTH-1:0] A_GIN  = ADDR_WIDTH'(8'hF1);
`ifdef DMEM_TIMER_EN
    localparam logic [ADDR_WIDTH-1:0] A_TMR  = ADDR_WIDTH'(8'hF2);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_write;

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [7:0] gin_s1, gin_s2;
`ifdef DMEM_TIMER_EN
    logic [DATA_WIDTH-1:0] tmr;
`endif

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic cur_write;
    logic accept, to_resp, commit;
    logic hit_ram, hit_gout, hit_gin, hit_tmr;
    logic rd_ok, wr_ok, err_nx;
    logic [DATA_WIDTH-1:0] rd_data;

    // The zero-wait build decides on the live request in IDLE; otherwise latched values.
    assign accept    = (state == IDLE) && req_valid;
    assign cur_addr  = (state == IDLE) ? req_addr : a_addr;
    assign cur_write = (state == IDLE) ? req_write : a_write;
    assign to_resp   = (state_nx == RESP) && (state != RESP);
    assign commit    = (state == RESP) && a_write;

    assign hit_ram  = cur_addr < ADDR_WIDTH'(DATA_DEPTH);
    assign hit_gout = cur_addr == A_GOUT;
    assign hit_gin  = cur_addr == A_GIN;
`ifdef DMEM_TIMER_EN
    assign hit_tmr  = cur_addr == A_TMR;
`else
    assign hit_tmr  = 1'b0;
`endif

    assign req_ready = (state == RESP);
    assign rsp_valid = (state == RESP);

    // State and wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: accept, count wait states, single-cycle response.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = WC;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request so later bus changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
            a_write <= req_write;
        end
    end

    // Address decode: read data and legality of the current access.
    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b0;
        wr_ok   = 1'b0;
        unique case (1'b1)
            hit_ram: begin
                rd_data = mem[cur_addr[IW-1:0]];
                rd_ok   = 1'b1;
                wr_ok   = 1'b1;
            end
            hit_gout: begin
                rd_data = DATA_WIDTH'(gpio_out);
                rd_ok   = 1'b1;
                wr_ok   = 1'b1;
            end
            hit_gin: begin
                rd_data = DATA_WIDTH'(gin_s2);
                rd_ok   = 1'b1;
            end
`ifdef DMEM_TIMER_EN
            hit_tmr: begin
                rd_data = tmr;
                rd_ok   = 1'b1;
                wr_ok   = 1'b1;
            end
`endif
            default: ;
        endcase
        err_nx = cur_write ? !wr_ok : !rd_ok;
    end

    // Response data and error flag, registered on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_err <= to_resp && err_nx;
            if (to_resp && !cur_write) rsp_rdata <= rd_data;
        end
    end

    // RAM store commits on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (commit && hit_ram) mem[a_addr[IW-1:0]] <= a_wdata;
    end

    // LED register write and two-flop switch synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
            gin_s1   <= '0;
            gin_s2   <= '0;
        end else begin
            gin_s1 <= gpio_in;
            gin_s2 <= gin_s1;
            if (commit && hit_gout) gpio_out <= 8'(a_wdata);
        end
    end

`ifdef DMEM_TIMER_EN
    // Free-running cycle counter, overwritten by a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr <= '0;
        else if (commit && hit_tmr) tmr <= a_wdata;
        else tmr <= tmr + 1'b1;
    end
`endif

endmodule
